// File: rtl/cipher_path_sequencer.sv
// cipher_path_sequencer: rotor-cipher letter pass sequenced one rotor stage per clock
module cipher_path_sequencer #(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_letter,
    input  logic [4:0] rotor1_pos,
    input  logic [4:0] rotor2_pos,
    input  logic [4:0] rotor3_pos,
    output logic       out_valid,
    output logic [4:0] out_letter,
    output logic [2:0] done_out
);
    localparam logic [207:0] W1 = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [207:0] W2 = "AJDKSIRUXBLHWTMCQGZNPYVOEF";
    localparam logic [207:0] W3 = "BDFHJLCPRTXVZNYEAIOGKMUSQW";
    localparam logic [207:0] WR = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    typedef enum logic [3:0] {IDLE, F1, F2, F3, REFL, B3, B2, B1, DONE, BYP} state_t;

    state_t       r_state;
    logic [4:0]   r_x;
    logic [4:0]   r_p1;
    logic [4:0]   r_p2;
    logic [4:0]   r_p3;
    logic         r_out_valid;
    logic [4:0]   r_out_letter;
    logic [2:0]   r_done;
    logic [4:0]   w_pos;
    logic [207:0] w_tab;
    logic         w_bwd;
    logic [4:0]   w_idx;
    logic [4:0]   w_y;
    logic [4:0]   w_res;

    function automatic logic [4:0] mod26(input logic [5:0] a);
        return (a >= 6'd26) ? 5'(a - 6'd26) : a[4:0];
    endfunction

    function automatic logic [4:0] fwd(input logic [207:0] w, input logic [4:0] i);
        logic [7:0] c;
        c = w[8*(25-int'(i)) +: 8];
        return 5'(c - 8'd65);
    endfunction

    function automatic logic [4:0] inv(input logic [207:0] w, input logic [4:0] i);
        logic [4:0] r;
        r = '0;
        for (int j = 0; j < 26; j++)
            if (w[8*(25-j) +: 8] == {3'b000, i} + 8'd65) r = 5'(j);
        return r;
    endfunction

    function automatic logic [4:0] clamp(input logic [4:0] p);
        return (p > 5'd25) ? 5'd0 : p;
    endfunction

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = r_out_valid;
    assign out_letter = r_out_letter;
    assign done_out   = r_done;

    // stage datapath: pick rotor/direction from the state, apply offset-wire-unoffset
    always_comb begin
        w_pos = (r_state == F1 || r_state == B1) ? r_p1 :
                (r_state == F2 || r_state == B2) ? r_p2 :
                (r_state == F3 || r_state == B3) ? r_p3 : 5'd0;
        w_tab = (r_state == F1 || r_state == B1) ? W1 :
                (r_state == F2 || r_state == B2) ? W2 :
                (r_state == F3 || r_state == B3) ? W3 : WR;
        w_bwd = (r_state == B3 || r_state == B2 || r_state == B1);
        w_idx = mod26({1'b0, r_x} + {1'b0, w_pos});
        w_y   = w_bwd ? inv(w_tab, w_idx) : fwd(w_tab, w_idx);
        w_res = mod26({1'b0, w_y} + 6'd26 - {1'b0, w_pos});
    end

    // sequencer FSM with registered result, strobe and per-rotor done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_p1         <= '0;
            r_p2         <= '0;
            r_p3         <= '0;
            r_out_valid  <= 1'b0;
            r_out_letter <= '0;
            r_done       <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    if (in_letter <= 5'd25) begin
                        r_x     <= in_letter;
                        r_p1    <= clamp(rotor1_pos);
                        r_p2    <= clamp(rotor2_pos);
                        r_p3    <= clamp(rotor3_pos);
                        r_state <= F1;
                    end else if (BYPASS_EN) begin
                        r_out_letter <= in_letter;
                        r_out_valid  <= 1'b1;
                        r_state      <= BYP;
                    end
                end
                F1: begin
                    r_x     <= w_res;
                    r_state <= F2;
                end
                F2: begin
                    r_x     <= w_res;
                    r_state <= F3;
                end
                F3: begin
                    r_x     <= w_res;
                    r_state <= REFL;
                end
                REFL: begin
                    r_x     <= w_res;
                    r_state <= B3;
                end
                B3: begin
                    r_x       <= w_res;
                    r_done[2] <= 1'b1;
                    r_state   <= B2;
                end
                B2: begin
                    r_x       <= w_res;
                    r_done[1] <= 1'b1;
                    r_state   <= B1;
                end
                B1: begin
                    r_out_letter <= w_res;
                    r_out_valid  <= 1'b1;
                    r_done[0]    <= 1'b1;
                    r_state      <= DONE;
                end
                DONE: begin
                    r_out_valid <= 1'b0;
                    r_done      <= '0;
                    r_state     <= IDLE;
                end
                BYP: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cipher_path_sequencer.sv
// tb_cipher_path_sequencer: randomized self-checking bench against a rotor-cipher reference model
module tb_cipher_path_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_letter = '0;
    logic [4:0] rotor1_pos = '0;
    logic [4:0] rotor2_pos = '0;
    logic [4:0] rotor3_pos = '0;
    logic       out_valid;
    logic [4:0] out_letter;
    logic [2:0] done_out;
    logic       in_valid0 = 1'b0;
    logic       in_ready0;
    logic [4:0] in_letter0 = '0;
    logic       out_valid0;
    logic [4:0] out_letter0;
    logic [2:0] done_out0;
    int checks = 0;
    int errors = 0;

    string W[4] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYVOEF",
                    "BDFHJLCPRTXVZNYEAIOGKMUSQW", "YRUHQSLDPXNGOKMIEBFZCWVJAT"};

    cipher_path_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_letter(in_letter),
        .rotor1_pos(rotor1_pos), .rotor2_pos(rotor2_pos), .rotor3_pos(rotor3_pos),
        .out_valid(out_valid), .out_letter(out_letter), .done_out(done_out)
    );

    cipher_path_sequencer #(.BYPASS_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_letter(in_letter0),
        .rotor1_pos(5'd0), .rotor2_pos(5'd0), .rotor3_pos(5'd0),
        .out_valid(out_valid0), .out_letter(out_letter0), .done_out(done_out0)
    );

    always #5 clk = ~clk;

    function automatic int wire_of(int r, int x);
        return int'(W[r].getc(x)) - 65;
    endfunction

    function automatic int wire_inv(int r, int y);
        for (int j = 0; j < 26; j++) if (wire_of(r, j) == y) return j;
        return -1;
    endfunction

    function automatic int model(int l, int a, int b, int c);
        int p[3];
        int x;
        if (l > 25) return l;
        p[0] = (a > 25) ? 0 : a;
        p[1] = (b > 25) ? 0 : b;
        p[2] = (c > 25) ? 0 : c;
        x = l;
        for (int r = 0; r < 3; r++) x = (wire_of(r, (x + p[r]) % 26) - p[r] + 26) % 26;
        x = wire_of(3, x);
        for (int r = 2; r >= 0; r--) x = (wire_inv(r, (x + p[r]) % 26) - p[r] + 26) % 26;
        return x;
    endfunction

    task automatic send(input logic [4:0] l, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input bit wiggle, output int res, output int lat,
                        output logic [2:0] d_at, output logic [2:0] d_after);
        int n;
        n = 0;
        lat = -1;
        res = -1;
        d_at = 'x;
        d_after = 'x;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        in_letter = l;
        rotor1_pos = a;
        rotor2_pos = b;
        rotor3_pos = c;
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (wiggle) rotor1_pos = 5'($urandom);
            if (lat >= 0) begin
                d_after = done_out;
                break;
            end
            if (out_valid) begin
                lat = k;
                res = int'(out_letter);
                d_at = done_out;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_letter !== 5'd0 || done_out !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%0d d=%b, want 0 0 000", out_valid, out_letter, done_out);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_kat;
        int res, lat;
        logic [2:0] da, db;
        send(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, res, lat, da, db);
        checks++;
        if (res != 13 || res != model(0, 0, 0, 0)) begin
            errors++;
            $display("FAIL kat_letter: got %0d, want 13", res);
        end
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL kat_latency: got %0d edges after accept, want 7 (8th cycle)", lat);
        end
        checks++;
        if (da !== 3'b111 || db !== 3'b000) begin
            errors++;
            $display("FAIL kat_done: got %b then %b, want 111 then 000", da, db);
        end
    endtask

    task automatic test_reciprocity;
        int res, back, lat, a, b, c, l;
        logic [2:0] da, db;
        send(5'd13, 5'd0, 5'd0, 5'd0, 1'b0, res, lat, da, db);
        checks++;
        if (res != 0) begin
            errors++;
            $display("FAIL recip_13: got %0d, want 0", res);
        end
        for (int i = 0; i < 8; i++) begin
            l = $urandom_range(0, 25);
            a = $urandom_range(0, 25);
            b = $urandom_range(0, 25);
            c = $urandom_range(0, 25);
            send(5'(l), 5'(a), 5'(b), 5'(c), 1'b0, res, lat, da, db);
            checks++;
            if (res != model(l, a, b, c) || res == l) begin
                errors++;
                $display("FAIL recip_fwd: L=%0d pos=%0d/%0d/%0d got %0d, want %0d", l, a, b, c, res, model(l, a, b, c));
            end
            send(5'(res), 5'(a), 5'(b), 5'(c), 1'b0, back, lat, da, db);
            checks++;
            if (back != l) begin
                errors++;
                $display("FAIL recip_back: C=%0d got %0d, want %0d", res, back, l);
            end
        end
    endtask

    task automatic test_pos_latch;
        int res, lat, a, b, c, l;
        logic [2:0] da, db;
        for (int i = 0; i < 4; i++) begin
            l = $urandom_range(0, 25);
            a = $urandom_range(0, 25);
            b = $urandom_range(0, 25);
            c = $urandom_range(0, 25);
            send(5'(l), 5'(a), 5'(b), 5'(c), 1'b1, res, lat, da, db);
            checks++;
            if (res != model(l, a, b, c)) begin
                errors++;
                $display("FAIL pos_latch: L=%0d got %0d, want %0d", l, res, model(l, a, b, c));
            end
        end
        l = $urandom_range(0, 25);
        b = $urandom_range(0, 25);
        send(5'(l), 5'd31, 5'(b), 5'd26, 1'b0, res, lat, da, db);
        checks++;
        if (res != model(l, 0, b, 0)) begin
            errors++;
            $display("FAIL pos_clamp: L=%0d got %0d, want %0d", l, res, model(l, 0, b, 0));
        end
    endtask

    task automatic test_bypass;
        int res, lat, seen;
        logic [2:0] da, db;
        send(5'd27, 5'd3, 5'd4, 5'd5, 1'b0, res, lat, da, db);
        checks++;
        if (res != 27 || lat != 0) begin
            errors++;
            $display("FAIL bypass_letter: got %0d at %0d, want 27 at 0", res, lat);
        end
        checks++;
        if (da !== 3'b000 || db !== 3'b000) begin
            errors++;
            $display("FAIL bypass_done: got %b/%b, want 000/000", da, db);
        end
        seen = 0;
        @(negedge clk);
        in_valid0 = 1'b1;
        in_letter0 = 5'd30;
        @(negedge clk);
        in_valid0 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid0 || !in_ready0 || done_out0 != 3'b000) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL bypass_drop: got %0d cycles with output/busy, want 0", seen);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1;
        in_letter = 5'($urandom_range(0, 25));
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready: got %b, want 1", in_ready);
        end
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid || done_out != 3'b000) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got %0d cycles with output, want 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        int q[$];
        int acc[$];
        int a, b, c, l, exp;
        int bad_sp, bad_res;
        a = $urandom_range(0, 25);
        b = $urandom_range(0, 25);
        c = $urandom_range(0, 25);
        rotor1_pos = 5'(a);
        rotor2_pos = 5'(b);
        rotor3_pos = 5'(c);
        bad_sp = 0;
        bad_res = 0;
        @(negedge clk);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (out_valid) begin
                if (q.size() == 0) bad_res++;
                else begin
                    exp = q.pop_front();
                    if (int'(out_letter) != exp) bad_res++;
                end
            end
            l = $urandom_range(0, 25);
            in_letter = 5'(l);
            if (in_ready) begin
                if (acc.size() > 0 && cyc - acc[$] != 9) bad_sp++;
                acc.push_back(cyc);
                q.push_back(model(l, a, b, c));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (bad_sp != 0 || acc.size() < 5) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d bad gaps over %0d accepts, want 0 bad and >=5", bad_sp, acc.size());
        end
        checks++;
        if (bad_res != 0) begin
            errors++;
            $display("FAIL b2b_results: got %0d wrong results, want 0", bad_res);
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_kat;
        test_reciprocity;
        test_pos_latch;
        test_bypass;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
